// File: rtl/vdc_pkg.sv
// Shared attribute bit positions and cursor mode encoding for the VDC pixel path.
package vdc_pkg;

  localparam int unsigned ATTR_RVS    = 6;
  localparam int unsigned ATTR_UL     = 5;
  localparam int unsigned ATTR_BLINK  = 4;
  localparam int unsigned ATTR_FG_MSB = 3;
  localparam int unsigned ATTR_FG_LSB = 0;

  typedef enum logic [1:0] {
    CM_STEADY = 2'b00,
    CM_OFF    = 2'b01,
    CM_FAST   = 2'b10,
    CM_SLOW   = 2'b11
  } cursor_mode_t;

endpackage

// File: rtl/vdc_blink.sv
// Frame counter providing the fast (1/16) and slow (1/32) blink phases.
module vdc_blink #(
  parameter int unsigned BLINK_BITS = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic frame,
  output logic blink_fast,
  output logic blink_slow
);

  logic [BLINK_BITS-1:0] fcnt_q, fcnt_d;

  // Count frame strobes, wrapping naturally at 2^BLINK_BITS.
  always_comb begin
    fcnt_d = fcnt_q;
    if (enable && frame) fcnt_d = fcnt_q + 1'b1;
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign blink_fast = fcnt_q[BLINK_BITS-2];
  assign blink_slow = fcnt_q[BLINK_BITS-1];

endmodule

// File: rtl/vdc_pixelshift.sv
// Character cell serialiser: shifts the cell byte out as RGBI pixels and
// applies underline, blink, cursor, reverse, semigraphics and doubling.
module vdc_pixelshift #(
  parameter int unsigned BLINK_BITS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       frame,
  input  logic       load,
  input  logic       de,
  input  logic [7:0] data_in,
  input  logic [7:0] attr_in,
  input  logic       cursor,
  input  logic [4:0] line,
  input  logic [3:0] reg_cth,
  input  logic [3:0] reg_cdh,
  input  logic [4:0] reg_ul,
  input  logic [4:0] reg_cs,
  input  logic [4:0] reg_ce,
  input  logic [1:0] reg_cm,
  input  logic       reg_atr,
  input  logic       reg_text,
  input  logic       reg_rvs,
  input  logic       reg_semi,
  input  logic       reg_dbl,
  input  logic [3:0] reg_fg,
  input  logic [3:0] reg_bg,
  output logic [3:0] rgbi
);
  import vdc_pkg::*;

  logic [7:0] shift_q, shift_d;
  logic [7:0] attr_q, attr_d;
  logic [3:0] pixcnt_q, pixcnt_d;
  logic       dblph_q, dblph_d;
  logic       last_q, last_d;
  logic       cursor_q, cursor_d;
  logic [4:0] line_q, line_d;
  logic [3:0] rgbi_q, rgbi_d;

  logic         blink_fast, blink_slow;
  logic [3:0]   lim;
  logic         in_disp;
  logic         pix;
  logic         curon;
  logic         advance;
  cursor_mode_t cm;

  vdc_blink #(.BLINK_BITS(BLINK_BITS)) u_blink (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .frame      (frame),
    .blink_fast (blink_fast),
    .blink_slow (blink_slow)
  );

  // Pixel effects, colour mux and next-state of the cell shifter.
  always_comb begin
    shift_d  = shift_q;
    attr_d   = attr_q;
    pixcnt_d = pixcnt_q;
    dblph_d  = dblph_q;
    last_d   = last_q;
    cursor_d = cursor_q;
    line_d   = line_q;
    rgbi_d   = rgbi_q;
    advance  = 1'b0;

    // Displayed width is clipped to the cell width.
    lim     = (reg_cdh > reg_cth) ? reg_cth : reg_cdh;
    in_disp = (pixcnt_q <= lim);
    pix     = in_disp ? shift_q[7] : (reg_semi & last_q);

    if (reg_text && attr_q[ATTR_UL] && (line_q == reg_ul)) pix = 1'b1;
    if (attr_q[ATTR_BLINK] && blink_fast) pix = 1'b0;

    cm    = cursor_mode_t'(reg_cm);
    curon = cursor_q && (cm != CM_OFF) && (line_q >= reg_cs) && (line_q <= reg_ce);
    if (cm == CM_FAST) curon = curon & blink_fast;
    if (cm == CM_SLOW) curon = curon & blink_slow;

    pix = pix ^ (attr_q[ATTR_RVS] ^ reg_rvs ^ curon);

    if (enable) begin
      rgbi_d = (!de) ? reg_bg : (pix ? attr_q[ATTR_FG_MSB:ATTR_FG_LSB] : reg_bg);
      if (load) begin
        shift_d  = data_in;
        attr_d   = reg_atr ? attr_in : {4'b0000, reg_fg};
        pixcnt_d = '0;
        dblph_d  = 1'b0;
        last_d   = 1'b0;
        cursor_d = cursor;
        line_d   = line;
      end else begin
        advance = !reg_dbl || dblph_q;
        if (reg_dbl) dblph_d = ~dblph_q;
        if (advance) begin
          pixcnt_d = (pixcnt_q >= reg_cth) ? reg_cth : pixcnt_q + 4'd1;
          shift_d  = {shift_q[6:0], 1'b0};
          // Remember the last displayed bit so semigraphics can extend it.
          if (in_disp) last_d = shift_q[7];
        end
      end
    end
  end

  // Cell state and output pixel registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q  <= '0;
      attr_q   <= '0;
      pixcnt_q <= '0;
      dblph_q  <= 1'b0;
      last_q   <= 1'b0;
      cursor_q <= 1'b0;
      line_q   <= '0;
      rgbi_q   <= '0;
    end else begin
      shift_q  <= shift_d;
      attr_q   <= attr_d;
      pixcnt_q <= pixcnt_d;
      dblph_q  <= dblph_d;
      last_q   <= last_d;
      cursor_q <= cursor_d;
      line_q   <= line_d;
      rgbi_q   <= rgbi_d;
    end
  end

  assign rgbi = rgbi_q;

endmodule

// File: tb/tb_vdc_pixelshift.sv
// Directed, table-driven bench for vdc_pixelshift.
module tb_vdc_pixelshift;

  logic       clk = 1'b0;
  logic       reset_n, enable, frame, load, de, cursor;
  logic [7:0] data_in, attr_in;
  logic [4:0] line, reg_ul, reg_cs, reg_ce;
  logic [3:0] reg_cth, reg_cdh, reg_fg, reg_bg;
  logic [1:0] reg_cm;
  logic       reg_atr, reg_text, reg_rvs, reg_semi, reg_dbl;
  logic [3:0] rgbi;

  int errors = 0;
  int checks = 0;
  int fcnt_m = 0;

  always #5 clk = ~clk;

  vdc_pixelshift #(.BLINK_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame(frame), .load(load),
    .de(de), .data_in(data_in), .attr_in(attr_in), .cursor(cursor), .line(line),
    .reg_cth(reg_cth), .reg_cdh(reg_cdh), .reg_ul(reg_ul), .reg_cs(reg_cs),
    .reg_ce(reg_ce), .reg_cm(reg_cm), .reg_atr(reg_atr), .reg_text(reg_text),
    .reg_rvs(reg_rvs), .reg_semi(reg_semi), .reg_dbl(reg_dbl), .reg_fg(reg_fg),
    .reg_bg(reg_bg), .rgbi(rgbi)
  );

  typedef struct {
    logic [7:0]  data, attr;
    logic        atr, text, rvs, semi, dbl, cur;
    logic [3:0]  fg, bg, cth, cdh;
    logic [4:0]  ul, cs, ce, ln;
    logic [1:0]  cm;
    int          nframes;
    int          npix;
    logic [63:0] exp;   // pixel 0 in the top nibble
  } vec_t;

  localparam int NV = 18;
  vec_t v [NV];

  function automatic vec_t dflt();
    vec_t d;
    d.data = 8'h00; d.attr = 8'h00; d.atr = 1'b0; d.text = 1'b1; d.rvs = 1'b0;
    d.semi = 1'b0; d.dbl = 1'b0; d.cur = 1'b0; d.fg = 4'h1; d.bg = 4'h0;
    d.cth = 4'd7; d.cdh = 4'd7; d.ul = 5'd31; d.cs = 5'd31; d.ce = 5'd0;
    d.ln = 5'd0; d.cm = 2'b01; d.nframes = 0; d.npix = 8; d.exp = '0;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rgbi=%h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t c);
    reg_atr = c.atr; reg_text = c.text; reg_rvs = c.rvs; reg_semi = c.semi;
    reg_dbl = c.dbl; reg_fg = c.fg; reg_bg = c.bg; reg_cth = c.cth;
    reg_cdh = c.cdh; reg_ul = c.ul; reg_cs = c.cs; reg_ce = c.ce; reg_cm = c.cm;
    cursor = c.cur; line = c.ln; data_in = c.data; attr_in = c.attr;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      tick();
      fcnt_m++;
    end
    frame = 1'b0;
  endtask

  initial begin
    vec_t c;
    logic [3:0] e;

    // Basic serialisation
    v[0] = dflt(); v[0].data = 8'hA5; v[0].npix = 10; v[0].exp = 64'h10100101_00000000;
    // Semigraphics extension vs background in the gap
    v[1] = dflt(); v[1].data = 8'h01; v[1].cth = 4'd9; v[1].semi = 1'b1; v[1].fg = 4'h3;
    v[1].bg = 4'h8; v[1].npix = 11; v[1].exp = 64'h88888883_33300000;
    v[2] = v[1]; v[2].semi = 1'b0; v[2].exp = 64'h88888883_88800000;
    // Pixel doubling
    v[3] = dflt(); v[3].data = 8'h80; v[3].dbl = 1'b1; v[3].fg = 4'h2; v[3].npix = 16;
    v[3].exp = 64'h22000000_00000000;
    // Cursor
    v[4] = dflt(); v[4].data = 8'h0F; v[4].fg = 4'h7; v[4].cur = 1'b1; v[4].cm = 2'b00;
    v[4].cs = 5'd2; v[4].ce = 5'd4; v[4].ln = 5'd2; v[4].exp = 64'h77770000_00000000;
    v[5] = v[4]; v[5].ln = 5'd4;
    v[6] = v[4]; v[6].ln = 5'd5; v[6].exp = 64'h00007777_00000000;
    v[7] = v[4]; v[7].ln = 5'd3; v[7].cm = 2'b01; v[7].exp = 64'h00007777_00000000;
    v[8] = v[4]; v[8].ln = 5'd3; v[8].cs = 5'd5; v[8].ce = 5'd2; v[8].exp = 64'h00007777_00000000;
    v[9] = v[8]; v[9].ln = 5'd5;
    v[10] = v[4]; v[10].rvs = 1'b1; v[10].ln = 5'd5;
    v[11] = v[4]; v[11].rvs = 1'b1; v[11].ln = 5'd3; v[11].exp = 64'h00007777_00000000;
    // Underline and blink
    v[12] = dflt(); v[12].atr = 1'b1; v[12].attr = 8'h35; v[12].ul = 5'd3; v[12].ln = 5'd3;
    v[12].bg = 4'hA; v[12].exp = 64'h55555555_00000000;
    v[13] = v[12]; v[13].nframes = 8; v[13].exp = 64'hAAAAAAAA_00000000;
    v[14] = v[12]; v[14].attr = 8'h25; v[14].text = 1'b0; v[14].data = 8'hF0;
    v[14].exp = 64'h5555AAAA_00000000;
    v[15] = v[14]; v[15].text = 1'b1; v[15].exp = 64'h55555555_00000000;
    v[16] = v[12]; v[16].attr = 8'h15; v[16].data = 8'hFF; v[16].nframes = 8;
    v[16].exp = 64'h55555555_00000000;
    // Attribute reverse
    v[17] = v[12]; v[17].attr = 8'h45; v[17].data = 8'hF0; v[17].exp = 64'hAAAA5555_00000000;

    // Reset
    set_cfg(dflt());
    reset_n = 1'b0; enable = 1'b0; frame = 1'b0; load = 1'b0; de = 1'b1;
    repeat (3) tick();
    chk("reset", rgbi, 4'h0);
    reset_n = 1'b1; enable = 1'b1;

    for (int i = 0; i < NV; i++) begin
      set_cfg(v[i]);
      frames(v[i].nframes);
      load = 1'b1; de = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < v[i].npix; k++) begin
        tick();
        chk($sformatf("vec%0d_px%0d", i, k), rgbi, v[i].exp[4*(15-k) +: 4]);
      end
    end

    // Load mid-cell aborts the current cell
    c = dflt(); c.data = 8'hA5; set_cfg(c);
    load = 1'b1; tick(); load = 1'b0;
    repeat (3) tick();
    data_in = 8'hFF; load = 1'b1; tick(); load = 1'b0;
    chk("midload_old_px3", rgbi, 4'h0);
    tick();
    chk("midload_new_px0", rgbi, 4'h1);
    tick();
    chk("midload_new_px1", rgbi, 4'h1);

    // enable=0 holds everything
    data_in = 8'hA5; load = 1'b1; tick(); load = 1'b0;
    tick();
    chk("hold_px0", rgbi, 4'h1);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_idle%0d", k), rgbi, 4'h1);
    end
    enable = 1'b1;
    tick();
    chk("hold_px1", rgbi, 4'h0);
    tick();
    chk("hold_px2", rgbi, 4'h1);

    // Frame and load in the same tick
    c = dflt(); c.atr = 1'b1; c.attr = 8'h11; c.data = 8'hFF; set_cfg(c);
    while ((fcnt_m % 16) != 7) frames(1);
    frame = 1'b1; load = 1'b1; tick(); fcnt_m++;
    frame = 1'b0; load = 1'b0;
    e = ((fcnt_m >> 3) & 1) != 0 ? 4'h0 : 4'h1;
    tick();
    chk("frame_load_px0", rgbi, e);
    tick();
    chk("frame_load_px1", rgbi, e);

    // Load with de=0 shows background, then cell pixels follow
    c = dflt(); c.data = 8'h80; c.bg = 4'h6; set_cfg(c);
    load = 1'b1; de = 1'b0; tick(); load = 1'b0; de = 1'b1;
    chk("de0_load_bg", rgbi, 4'h6);
    tick();
    chk("de0_next_px0", rgbi, 4'h1);
    tick();
    chk("de0_next_px1", rgbi, 4'h6);

    // Reset mid-cell, independent of enable
    c = dflt(); c.data = 8'hFF; set_cfg(c);
    load = 1'b1; tick(); load = 1'b0;
    tick();
    chk("rst_pre", rgbi, 4'h1);
    reset_n = 1'b0; enable = 1'b0;
    tick();
    chk("rst_mid", rgbi, 4'h0);
    reset_n = 1'b1; enable = 1'b1; fcnt_m = 0;
    tick();
    chk("rst_after", rgbi, 4'h0);
    tick();
    chk("rst_after2", rgbi, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
